tanh_table_fetcher: RTL and testbench

Upstream stage of the tanh interpolator. Accepts a signed Q3.4 argument over a valid/ready handshake and splits it into its integer part. It then reads the two bracketing tanh samples from a 16-entry table using a 1-cycle synchronous read. It presents `z_value`, `base`, `next_data` and `integer_part` together, held stable, to the combinational interpolator downstream.

---
 rtl/tanh_pkg.sv | 34 +++
 rtl/tanh_table_fetcher_if.sv | 43 ++++
 rtl/tanh_table.sv | 56 +++++
 rtl/tanh_table_fetcher.sv | 118 +++++++++++
 tb/tb_tanh_table_fetcher.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/tanh_pkg.sv
// tanh_pkg: shared constants, FSM state type and default tanh table for the fetcher.
`default_nettype none

package tanh_pkg;

    localparam int Q_W    = 8;
    localparam int Q_FRAC = 4;
    localparam int TBL_N  = 16;
    localparam int TBL_AW = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_BASE = 3'd1,
        ST_RD_NEXT = 3'd2,
        ST_RD_LAST = 3'd3,
        ST_OUT     = 3'd4
    } state_e;

    typedef logic [Q_W-1:0] tbl_t [TBL_N];

    // round(16*tanh(k)) for k = -8..+7, entry 0 holds k = -8
    localparam tbl_t TANH_DEFAULT = '{
        8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF1, 8'hF4,
        8'h00, 8'h0C, 8'h0F, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10
    };

    // idx + 8 for idx = z >>> 4 is the integer field with its sign bit flipped
    function automatic logic [TBL_AW-1:0] tbl_addr_of(input logic [Q_W-1:0] z);
        return {~z[Q_W-1], z[Q_W-2:Q_FRAC]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/tanh_table_fetcher_if.sv
// tanh_table_fetcher_if: argument/result handshake bundle (optional table write port: TANH_FETCH_PROG_EN).
`default_nettype none

interface tanh_table_fetcher_if;
    import tanh_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [Q_W-1:0]      in_z;
    logic                out_valid;
    logic                out_ready;
    logic [Q_W-1:0]      z_value;
    logic [Q_W-1:0]      integer_part;
    logic [Q_W-1:0]      base;
    logic [Q_W-1:0]      next_data;
`ifdef TANH_FETCH_PROG_EN
    logic                tbl_we;
    logic [TBL_AW-1:0]   tbl_addr;
    logic [Q_W-1:0]      tbl_wdata;
    logic                tbl_wready;

    modport slave (
        input  in_valid, in_z, out_ready, tbl_we, tbl_addr, tbl_wdata,
        output in_ready, out_valid, z_value, integer_part, base, next_data, tbl_wready
    );
    modport master (
        output in_valid, in_z, out_ready, tbl_we, tbl_addr, tbl_wdata,
        input  in_ready, out_valid, z_value, integer_part, base, next_data, tbl_wready
    );
`else
    modport slave (
        input  in_valid, in_z, out_ready,
        output in_ready, out_valid, z_value, integer_part, base, next_data
    );
    modport master (
        output in_valid, in_z, out_ready,
        input  in_ready, out_valid, z_value, integer_part, base, next_data
    );
`endif

endinterface

`default_nettype wire

// File: rtl/tanh_table.sv
// tanh_table: 16-entry tanh sample table, 1-cycle synchronous read; writable
// register file under TANH_FETCH_PROG_EN, constant ROM otherwise.  Rev 1.0
`default_nettype none

module tanh_table
    import tanh_pkg::*;
#(
    parameter int TBL_DEPTH = 16,
    parameter int DW        = 8,
    parameter int AW        = $clog2(TBL_DEPTH)
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    input  wire logic [AW-1:0] raddr_i,
    output logic      [DW-1:0] rdata_o
`ifdef TANH_FETCH_PROG_EN
    ,
    input  wire logic          we_i,
    input  wire logic [AW-1:0] waddr_i,
    input  wire logic [DW-1:0] wdata_i
`endif
);

    logic [DW-1:0] rdata_q;

`ifdef TANH_FETCH_PROG_EN
    logic [DW-1:0] mem_q [TBL_DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < TBL_DEPTH; i++) begin
                mem_q[i] <= TANH_DEFAULT[i];
            end
            rdata_q <= '0;
        end else begin
            if (we_i) begin
                mem_q[waddr_i] <= wdata_i;
            end
            rdata_q <= mem_q[raddr_i];
        end
    end
`else
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= TANH_DEFAULT[raddr_i];
        end
    end
`endif

    assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/tanh_table_fetcher.sv
// tanh_table_fetcher: latches a Q3.4 argument and fetches its two bracketing tanh
// samples for the interpolator. Optional table write port: TANH_FETCH_PROG_EN.  Rev 1.0
`default_nettype none

module tanh_table_fetcher
    import tanh_pkg::*;
#(
    parameter int TBL_DEPTH = 16,
    parameter int DW        = 8
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    tanh_table_fetcher_if.slave bus
);

    state_e          state_q;
    logic            in_ready_q;
    logic            out_valid_q;
    logic [DW-1:0]   z_q;
    logic [DW-1:0]   int_q;
    logic [DW-1:0]   base_q;
    logic [DW-1:0]   next_q;

    logic [TBL_AW-1:0] w_base_addr;
    logic [TBL_AW-1:0] w_next_addr;
    logic [TBL_AW-1:0] w_raddr;
    logic [DW-1:0]     w_rdata;

    assign w_base_addr = tbl_addr_of(z_q);
    // The upper neighbour of the last entry is itself, so next_data == base there
    assign w_next_addr = (w_base_addr == TBL_AW'(TBL_N - 1)) ? w_base_addr : w_base_addr + 1'b1;

    always_comb begin
        w_raddr = w_base_addr;
        if (state_q == ST_RD_NEXT) begin
            w_raddr = w_next_addr;
        end
    end

`ifdef TANH_FETCH_PROG_EN
    logic w_we;
    assign w_we           = bus.tbl_we & in_ready_q;
    assign bus.tbl_wready = in_ready_q;
`endif

    tanh_table #(
        .TBL_DEPTH (TBL_DEPTH),
        .DW        (DW)
    ) u_table (
        .clk     (clk),
        .rst_n   (rst_n),
        .raddr_i (w_raddr),
        .rdata_o (w_rdata)
`ifdef TANH_FETCH_PROG_EN
        ,
        .we_i    (w_we),
        .waddr_i (bus.tbl_addr),
        .wdata_i (bus.tbl_wdata)
`endif
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            z_q         <= '0;
            int_q       <= '0;
            base_q      <= '0;
            next_q      <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        z_q        <= bus.in_z;
                        int_q      <= {bus.in_z[DW-1:Q_FRAC], {Q_FRAC{1'b0}}};
                        in_ready_q <= 1'b0;
                        state_q    <= ST_RD_BASE;
                    end
                end
                ST_RD_BASE: begin
                    state_q <= ST_RD_NEXT;
                end
                ST_RD_NEXT: begin
                    base_q  <= w_rdata;
                    state_q <= ST_RD_LAST;
                end
                ST_RD_LAST: begin
                    next_q      <= w_rdata;
                    out_valid_q <= 1'b1;
                    state_q     <= ST_OUT;
                end
                ST_OUT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.z_value      = z_q;
    assign bus.integer_part = int_q;
    assign bus.base         = base_q;
    assign bus.next_data    = next_q;

endmodule

`default_nettype wire

// File: tb/tb_tanh_table_fetcher.sv
// tb_tanh_table_fetcher: directed vectors with hand-computed tanh table results.
`default_nettype none
`timescale 1ns/1ps

module tb_tanh_table_fetcher;
    import tanh_pkg::*;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_mis;

    tanh_table_fetcher_if bus();

    tanh_table_fetcher #(
        .TBL_DEPTH (16),
        .DW        (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer z in IDLE and return #1 after the accepting edge
    task automatic accept(input logic [7:0] z);
        chk("in_ready_idle", 8'(bus.in_ready), 8'h01);
        bus.in_valid = 1'b1;
        bus.in_z     = z;
        tick();
        bus.in_valid = 1'b0;
        chk("in_ready_busy", 8'(bus.in_ready), 8'h00);
    endtask

    task automatic finish_txn(input logic [7:0] z, input logic [7:0] ip,
                              input logic [7:0] b, input logic [7:0] n);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("latency", 8'(bus.out_valid), 8'(i == 2));
        end
        chk("z_value", bus.z_value, z);
        chk("integer_part", bus.integer_part, ip);
        chk("base", bus.base, b);
        chk("next_data", bus.next_data, n);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("out_valid_drop", 8'(bus.out_valid), 8'h00);
        chk("in_ready_back", 8'(bus.in_ready), 8'h01);
    endtask

    typedef struct {
        logic [7:0] z;
        logic [7:0] ip;
        logic [7:0] b;
        logic [7:0] n;
    } vec_t;

    vec_t vecs [6];

    initial begin
        n_cmp = 0;
        n_mis = 0;
        vecs[0] = '{8'h18, 8'h10, 8'h0C, 8'h0F};  // +1.5
        vecs[1] = '{8'hF8, 8'hF0, 8'hF4, 8'h00};  // -0.5 floors to -1
        vecs[2] = '{8'h7F, 8'h70, 8'h10, 8'h10};  // top saturation
        vecs[3] = '{8'h80, 8'h80, 8'hF0, 8'hF0};  // bottom of range
        vecs[4] = '{8'h00, 8'h00, 8'h00, 8'h0C};
        vecs[5] = '{8'hE0, 8'hE0, 8'hF1, 8'hF4};  // -2.0

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_z      = 8'h00;
        bus.out_ready = 1'b0;
`ifdef TANH_FETCH_PROG_EN
        bus.tbl_we    = 1'b0;
        bus.tbl_addr  = 4'd0;
        bus.tbl_wdata = 8'h00;
`endif
        tick();
        tick();
        chk("rst_in_ready", 8'(bus.in_ready), 8'h01);
        chk("rst_out_valid", 8'(bus.out_valid), 8'h00);
        chk("rst_z_value", bus.z_value, 8'h00);
        chk("rst_base", bus.base, 8'h00);
        rst_n = 1'b1;
        tick();

        foreach (vecs[k]) begin
            accept(vecs[k].z);
            finish_txn(vecs[k].z, vecs[k].ip, vecs[k].b, vecs[k].n);
        end

        // Backpressure: bundle must hold and a pending argument must wait
        accept(8'h7F);
        repeat (3) tick();
        chk("hold_ov", 8'(bus.out_valid), 8'h01);
        bus.in_valid = 1'b1;
        bus.in_z     = 8'h30;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_z", bus.z_value, 8'h7F);
            chk("hold_base", bus.base, 8'h10);
            chk("hold_in_ready", 8'(bus.in_ready), 8'h00);
            chk("hold_ov", 8'(bus.out_valid), 8'h01);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("release_in_ready", 8'(bus.in_ready), 8'h01);
        chk("release_z_kept", bus.z_value, 8'h7F);
        tick();
        bus.in_valid = 1'b0;
        chk("late_accept_z", bus.z_value, 8'h30);
        chk("late_accept_busy", 8'(bus.in_ready), 8'h00);
        finish_txn(8'h30, 8'h30, 8'h10, 8'h10);

        // Reset while in RD_NEXT
        accept(8'h18);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_in_ready", 8'(bus.in_ready), 8'h01);
        chk("midrst_out_valid", 8'(bus.out_valid), 8'h00);
        chk("midrst_z", bus.z_value, 8'h00);
        chk("midrst_ip", bus.integer_part, 8'h00);
        chk("midrst_base", bus.base, 8'h00);
        chk("midrst_next", bus.next_data, 8'h00);
        tick();
        chk("midrst_stays_idle", 8'(bus.out_valid), 8'h00);

`ifdef TANH_FETCH_PROG_EN
        // Write coinciding with accept is seen by that argument's reads
        chk("wready_idle", 8'(bus.tbl_wready), 8'h01);
        bus.tbl_we    = 1'b1;
        bus.tbl_addr  = 4'd9;
        bus.tbl_wdata = 8'h0A;
        accept(8'h10);
        bus.tbl_we    = 1'b0;
        finish_txn(8'h10, 8'h10, 8'h0A, 8'h0F);

        // Write during RD_BASE is dropped
        accept(8'h10);
        chk("wready_busy", 8'(bus.tbl_wready), 8'h00);
        bus.tbl_we    = 1'b1;
        bus.tbl_addr  = 4'd9;
        bus.tbl_wdata = 8'h55;
        tick();
        bus.tbl_we    = 1'b0;
        repeat (2) tick();
        chk("dropped_write_base", bus.base, 8'h0A);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        accept(8'h08);
        finish_txn(8'h08, 8'h00, 8'h00, 8'h0A);

        // Reset reloads the defaults
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        accept(8'h10);
        finish_txn(8'h10, 8'h10, 8'h0C, 8'h0F);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
